// File: rtl/multicycle_control_fsm.sv
// Control sequencer for the multicycle machine.
// Walks each instruction through fetch/decode/execute/memory/writeback and
// drives every datapath select and enable as a Moore decode of the current
// state. Also handles memory wait states with timeout, conditional branch,
// jump, illegal-opcode trap, halt, run/stop gating and retired-instruction count.
// Ports:
//   i_clk, i_clear (sync active-high), i_run, i_opcode, i_zero, i_mem_ready
//   o_pc_write, o_pc_write_cond, o_pc_or_data, o_mem_read, o_mem_write,
//   o_ir_write, o_reg_write, o_alu_src_a        : 1-bit enables/selects
//   o_mem_to_reg, o_alu_src_b, o_alu_op, o_pc_source : 2-bit mux selects
//   o_halted, o_trap, o_state_out[3:0], o_instr_count[CNT_W-1:0]
module multicycle_control_fsm #(
  parameter int unsigned OPCODE_W    = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WAIT_W      = 4,
  parameter int unsigned WAIT_LIMIT  = 15,
  parameter int unsigned TRAP_ENABLE = 1
) (
  input  logic                i_clk,
  input  logic                i_clear,
  input  logic                i_run,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_zero,
  input  logic                i_mem_ready,
  output logic                o_pc_write,
  output logic                o_pc_write_cond,
  output logic                o_pc_or_data,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic                o_ir_write,
  output logic                o_reg_write,
  output logic                o_alu_src_a,
  output logic [1:0]          o_mem_to_reg,
  output logic [1:0]          o_alu_src_b,
  output logic [1:0]          o_alu_op,
  output logic [1:0]          o_pc_source,
  output logic                o_halted,
  output logic                o_trap,
  output logic [3:0]          o_state_out,
  output logic [CNT_W-1:0]    o_instr_count
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_EXEC_I   = 4'd8,
    S_WB_ALU   = 4'd9,
    S_WB_IMM   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13,
    S_HALT     = 4'd14
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WAIT_W-1:0]   r_wait;
  logic [WAIT_W-1:0]   w_wait_inc;
  logic [CNT_W-1:0]    r_count;
  logic                r_is_store;
  logic                w_retire;
  logic                w_bad_op;
  logic                w_stall;
  logic                w_timeout;
  logic                w_op_hi;
  logic [3:0]          w_op_lo;

  assign w_op_lo    = i_opcode[3:0];
  assign w_op_hi    = (i_opcode >> 4) != '0;
  assign w_stall    = ((r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                       (r_state == S_MEM_WR)) && !i_mem_ready;
  assign w_wait_inc = r_wait + WAIT_W'(1);
  // The stall cycle that brings the wait count up to the limit is the last one.
  assign w_timeout  = w_stall && (WAIT_LIMIT != 0) &&
                      (w_wait_inc == WAIT_W'(WAIT_LIMIT));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_clear) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state and Moore output decode
  always_comb begin
    w_next          = r_state;
    w_retire        = 1'b0;
    w_bad_op        = 1'b0;
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_pc_or_data    = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_ir_write      = 1'b0;
    o_reg_write     = 1'b0;
    o_alu_src_a     = 1'b0;
    o_mem_to_reg    = 2'b00;
    o_alu_src_b     = 2'b00;
    o_alu_op        = 2'b00;
    o_pc_source     = 2'b00;
    o_halted        = 1'b0;
    o_trap          = 1'b0;
    case (r_state)
      S_IDLE: if (i_run) w_next = S_FETCH;
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = 2'b01;
        // IR and PC load only on the cycle the fetch completes.
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
        if (i_mem_ready)    w_next = S_DECODE;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_DECODE: begin
        o_alu_src_b = 2'b11;
        if (w_op_hi) begin
          w_bad_op = 1'b1;
        end else begin
          case (w_op_lo)
            4'h0, 4'h1, 4'h2, 4'h3,
            4'h4, 4'h5, 4'h6, 4'h7: w_next = S_EXEC_R;
            4'h8:                   w_next = S_EXEC_I;
            4'h9, 4'hA:             w_next = S_MEM_ADDR;
            4'hB:                   w_next = S_WB_IMM;
            4'hC:                   w_next = S_BRANCH;
            4'hD:                   w_next = S_JUMP;
            4'hF:                   w_next = S_HALT;
            default:                w_bad_op = 1'b1;
          endcase
        end
        if (w_bad_op) begin
          if (TRAP_ENABLE != 0) w_next   = S_TRAP;
          else                  w_retire = 1'b1;
        end
      end
      S_MEM_ADDR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        w_next      = r_is_store ? S_MEM_WR : S_MEM_RD;
      end
      S_EXEC_I: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        w_next      = S_WB_ALU;
      end
      S_EXEC_R: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = 2'b10;
        w_next      = S_WB_ALU;
      end
      S_MEM_RD: begin
        o_mem_read   = 1'b1;
        o_pc_or_data = 1'b1;
        if (i_mem_ready)    w_next = S_MEM_WB;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_MEM_WR: begin
        o_mem_write  = 1'b1;
        o_pc_or_data = 1'b1;
        if (i_mem_ready)    w_retire = 1'b1;
        else if (w_timeout) w_next   = S_TRAP;
      end
      S_MEM_WB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 2'b01;
        w_retire     = 1'b1;
      end
      S_WB_ALU: begin
        o_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_WB_IMM: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 2'b10;
        w_retire     = 1'b1;
      end
      S_BRANCH: begin
        o_alu_src_a     = 1'b1;
        o_alu_op        = 2'b01;
        o_pc_write_cond = 1'b1;
        o_pc_source     = 2'b01;
        w_retire        = 1'b1;
      end
      S_JUMP: begin
        o_pc_write  = 1'b1;
        o_pc_source = 2'b10;
        w_retire    = 1'b1;
      end
      S_TRAP: begin
        o_pc_write  = 1'b1;
        o_pc_source = 2'b11;
        o_trap      = 1'b1;
        w_retire    = 1'b1;
      end
      S_HALT: o_halted = 1'b1;
      default: w_next = S_IDLE;
    endcase
    if (w_retire) w_next = i_run ? S_FETCH : S_IDLE;
  end

  // Wait counter, retire counter and LOAD/STORE memo taken at decode
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_wait     <= '0;
      r_count    <= '0;
      r_is_store <= 1'b0;
    end else begin
      if (w_next != r_state) r_wait <= '0;
      else if (w_stall)      r_wait <= w_wait_inc;
      if (w_retire)          r_count <= r_count + CNT_W'(1);
      if (r_state == S_DECODE) r_is_store <= (w_op_lo == 4'hA) && !w_op_hi;
    end
  end

  assign o_state_out   = 4'(r_state);
  assign o_instr_count = r_count;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  localparam int unsigned S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEM_ADDR = 3,
    S_MEM_RD = 4, S_MEM_WB = 5, S_MEM_WR = 6, S_EXEC_R = 7, S_EXEC_I = 8,
    S_WB_ALU = 9, S_WB_IMM = 10, S_BRANCH = 11, S_JUMP = 12, S_TRAP = 13, S_HALT = 14;

  typedef struct {
    int unsigned st;
    logic        rdy;
    logic        rn;
    logic        z;
    logic [3:0]  op;
  } step_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear = 1'b1;
  logic       run = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] opcode = 4'h0;

  logic a_pw, a_pwc, a_pod, a_mr, a_mw, a_irw, a_rw, a_asa, a_hlt, a_trp;
  logic [1:0] a_m2r, a_asb, a_aop, a_pcs;
  logic [3:0] a_state;
  logic [15:0] a_count;
  logic b_pw, b_pwc, b_pod, b_mr, b_mw, b_irw, b_rw, b_asa, b_hlt, b_trp;
  logic [1:0] b_m2r, b_asb, b_aop, b_pcs;
  logic [3:0] b_state;
  logic [1:0] b_count;
  logic [17:0] a_outs;

  assign a_outs = {a_pw, a_pwc, a_pod, a_mr, a_mw, a_irw, a_rw, a_asa,
                   a_m2r, a_asb, a_aop, a_pcs, a_hlt, a_trp};

  multicycle_control_fsm dut (
    .i_clk(clk), .i_clear(clear), .i_run(run), .i_opcode(opcode), .i_zero(zero),
    .i_mem_ready(mem_ready), .o_pc_write(a_pw), .o_pc_write_cond(a_pwc),
    .o_pc_or_data(a_pod), .o_mem_read(a_mr), .o_mem_write(a_mw), .o_ir_write(a_irw),
    .o_reg_write(a_rw), .o_alu_src_a(a_asa), .o_mem_to_reg(a_m2r), .o_alu_src_b(a_asb),
    .o_alu_op(a_aop), .o_pc_source(a_pcs), .o_halted(a_hlt), .o_trap(a_trp),
    .o_state_out(a_state), .o_instr_count(a_count)
  );

  // Narrow counter, timeout disabled, illegal opcodes retire as NOPs.
  multicycle_control_fsm #(.CNT_W(2), .WAIT_LIMIT(0), .TRAP_ENABLE(0)) dut2 (
    .i_clk(clk), .i_clear(clear), .i_run(run), .i_opcode(opcode), .i_zero(zero),
    .i_mem_ready(mem_ready), .o_pc_write(b_pw), .o_pc_write_cond(b_pwc),
    .o_pc_or_data(b_pod), .o_mem_read(b_mr), .o_mem_write(b_mw), .o_ir_write(b_irw),
    .o_reg_write(b_rw), .o_alu_src_a(b_asa), .o_mem_to_reg(b_m2r), .o_alu_src_b(b_asb),
    .o_alu_op(b_aop), .o_pc_source(b_pcs), .o_halted(b_hlt), .o_trap(b_trp),
    .o_state_out(b_state), .o_instr_count(b_count)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned m_count = 0;
  step_t       q[$];
  logic [22:0] got[$];
  logic [22:0] want[$];

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected datapath controls for a state, straight from the state table.
  function automatic logic [17:0] exp_out(input int unsigned st, input logic rdy);
    logic pw, pwc, pod, mr, mw, irw, rw, asa, hlt, trp;
    logic [1:0] m2r, asb, aop, pcs;
    {pw, pwc, pod, mr, mw, irw, rw, asa, hlt, trp} = '0;
    {m2r, asb, aop, pcs} = '0;
    case (st)
      S_FETCH:    begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
      S_DECODE:   asb = 2'b11;
      S_MEM_ADDR, S_EXEC_I: begin asa = 1; asb = 2'b10; end
      S_MEM_RD:   begin mr = 1; pod = 1; end
      S_MEM_WR:   begin mw = 1; pod = 1; end
      S_MEM_WB:   begin rw = 1; m2r = 2'b01; end
      S_EXEC_R:   begin asa = 1; aop = 2'b10; end
      S_WB_ALU:   rw = 1;
      S_WB_IMM:   begin rw = 1; m2r = 2'b10; end
      S_BRANCH:   begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
      S_JUMP:     begin pw = 1; pcs = 2'b10; end
      S_TRAP:     begin pw = 1; pcs = 2'b11; trp = 1; end
      S_HALT:     hlt = 1;
      default:    ;
    endcase
    return {pw, pwc, pod, mr, mw, irw, rw, asa, m2r, asb, aop, pcs, hlt, trp};
  endfunction

  task automatic push(input int unsigned st, input logic rdy, input logic rn,
                      input logic z, input logic [3:0] op);
    step_t s;
    s.st = st; s.rdy = rdy; s.rn = rn; s.z = z; s.op = op;
    q.push_back(s);
  endtask

  // Expected cycle-by-cycle path of one instruction (opcodes 0x0..0xE).
  task automatic add_instr(input logic [3:0] op, input int unsigned sf,
                           input int unsigned sm, input logic z, input logic run_after);
    int unsigned ret;
    for (int unsigned i = 0; i < sf; i++) push(S_FETCH, 1'b0, rb(), rb(), op);
    push(S_FETCH, 1'b1, rb(), rb(), op);
    push(S_DECODE, rb(), rb(), rb(), op);
    if (op < 4'd8) begin
      push(S_EXEC_R, rb(), rb(), rb(), op); ret = S_WB_ALU;
    end else begin
      case (op)
        4'd8:  begin push(S_EXEC_I, rb(), rb(), rb(), op); ret = S_WB_ALU; end
        4'd9:  begin
          push(S_MEM_ADDR, rb(), rb(), rb(), op);
          for (int unsigned i = 0; i < sm; i++) push(S_MEM_RD, 1'b0, rb(), rb(), op);
          push(S_MEM_RD, 1'b1, rb(), rb(), op);
          ret = S_MEM_WB;
        end
        4'd10: begin
          push(S_MEM_ADDR, rb(), rb(), rb(), op);
          for (int unsigned i = 0; i < sm; i++) push(S_MEM_WR, 1'b0, rb(), rb(), op);
          ret = S_MEM_WR;
        end
        4'd11: ret = S_WB_IMM;
        4'd12: ret = S_BRANCH;
        4'd13: ret = S_JUMP;
        default: ret = S_TRAP;
      endcase
    end
    push(ret, (ret == S_MEM_WR) ? 1'b1 : rb(), run_after, z, op);
    m_count++;
  endtask

  // Drive queued cycles; record observed vs expected {state, controls, pc update}.
  task automatic play();
    step_t s;
    logic  eu;
    got.delete(); want.delete();
    while (q.size() > 0) begin
      s = q.pop_front();
      mem_ready = s.rdy; run = s.rn; zero = s.z; opcode = s.op;
      #1;
      eu = ((s.st == S_FETCH) && s.rdy) || (s.st == S_JUMP) || (s.st == S_TRAP) ||
           ((s.st == S_BRANCH) && s.z);
      want.push_back({4'(s.st), exp_out(s.st, s.rdy), eu});
      got.push_back({a_state, a_outs, a_pw | (a_pwc & zero)});
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    clear = 1'b1; run = 1'b1; mem_ready = 1'b1; opcode = 4'h2;
    repeat (3) @(posedge clk);
    #1;
    clear = 1'b0; run = 1'b0;
    #1;
    n_cmp++; if (a_state !== 4'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", a_state); end
    n_cmp++; if (a_outs !== 18'd0) begin n_bad++; $display("FAIL reset_outs got %h want 0", a_outs); end
    n_cmp++; if (a_count !== 16'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", a_count); end
    n_cmp++; if (b_state !== 4'd0) begin n_bad++; $display("FAIL reset_state2 got %0d want 0", b_state); end
    @(posedge clk); #1;
    n_cmp++; if (a_state !== 4'd0) begin n_bad++; $display("FAIL idle_hold got %0d want 0", a_state); end
  endtask

  task automatic test_rtype();
    push(S_IDLE, rb(), 1'b1, rb(), 4'h0);
    add_instr(4'h2, 0, 0, rb(), 1'b1);
    add_instr(4'hB, 0, 0, rb(), 1'b0);
    play();
    foreach (got[i]) begin
      n_cmp++; if (got[i] !== want[i]) begin n_bad++; $display("FAIL rtype step %0d got %h want %h", i, got[i], want[i]); end
    end
    n_cmp++; if (a_count !== 16'(m_count)) begin n_bad++; $display("FAIL rtype_count got %0d want %0d", a_count, m_count); end
  endtask

  task automatic test_load_wait();
    push(S_IDLE, rb(), 1'b1, rb(), 4'h0);
    add_instr(4'h9, 0, 3, rb(), 1'b0);
    play();
    foreach (got[i]) begin
      n_cmp++; if (got[i] !== want[i]) begin n_bad++; $display("FAIL load_wait step %0d got %h want %h", i, got[i], want[i]); end
    end
    n_cmp++; if (a_count !== 16'(m_count)) begin n_bad++; $display("FAIL load_count got %0d want %0d", a_count, m_count); end
  endtask

  task automatic test_timeout();
    push(S_IDLE, rb(), 1'b1, rb(), 4'h0);
    for (int unsigned i = 0; i < 15; i++) push(S_FETCH, 1'b0, rb(), rb(), 4'h0);
    push(S_TRAP, rb(), 1'b1, rb(), 4'h0);
    m_count++;
    add_instr(4'hD, 0, 0, rb(), 1'b0);
    play();
    foreach (got[i]) begin
      n_cmp++; if (got[i] !== want[i]) begin n_bad++; $display("FAIL timeout step %0d got %h want %h", i, got[i], want[i]); end
    end
    n_cmp++; if (a_count !== 16'(m_count)) begin n_bad++; $display("FAIL timeout_count got %0d want %0d", a_count, m_count); end
  endtask

  task automatic test_beq();
    int unsigned taken;
    taken = 0;
    push(S_IDLE, rb(), 1'b1, rb(), 4'h0);
    add_instr(4'hC, 0, 0, 1'b0, 1'b1);
    add_instr(4'hC, 0, 0, 1'b1, 1'b0);
    play();
    foreach (got[i]) begin
      n_cmp++; if (got[i] !== want[i]) begin n_bad++; $display("FAIL beq step %0d got %h want %h", i, got[i], want[i]); end
      if ((got[i][22:19] == 4'd11) && got[i][0]) taken++;
    end
    n_cmp++; if (taken != 1) begin n_bad++; $display("FAIL beq_taken got %0d want 1", taken); end
  endtask

  task automatic test_random();
    logic ra;
    push(S_IDLE, rb(), 1'b1, rb(), 4'h0);
    for (int unsigned i = 0; i < 60; i++) begin
      ra = (i == 59) ? 1'b0 : ($urandom_range(0, 3) != 0);
      add_instr(4'($urandom_range(0, 14)), $urandom_range(0, 4), $urandom_range(0, 4), rb(), ra);
      if (!ra && i < 59) begin
        push(S_IDLE, rb(), 1'b0, rb(), 4'h0);
        push(S_IDLE, rb(), 1'b1, rb(), 4'h0);
      end
    end
    play();
    foreach (got[i]) begin
      n_cmp++; if (got[i] !== want[i]) begin n_bad++; $display("FAIL random step %0d got %h want %h", i, got[i], want[i]); end
    end
    n_cmp++; if (a_count !== 16'(m_count)) begin n_bad++; $display("FAIL random_count got %0d want %0d", a_count, m_count); end
  endtask

  task automatic test_clear_mid();
    push(S_IDLE, rb(), 1'b1, rb(), 4'h9);
    push(S_FETCH, 1'b1, rb(), rb(), 4'h9);
    push(S_DECODE, rb(), rb(), rb(), 4'h9);
    push(S_MEM_ADDR, rb(), rb(), rb(), 4'h9);
    push(S_MEM_RD, 1'b0, rb(), rb(), 4'h9);
    push(S_MEM_RD, 1'b0, rb(), rb(), 4'h9);
    play();
    foreach (got[i]) begin
      n_cmp++; if (got[i] !== want[i]) begin n_bad++; $display("FAIL clear_mid step %0d got %h want %h", i, got[i], want[i]); end
    end
    clear = 1'b1; run = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; run = 1'b0; m_count = 0;
    #1;
    n_cmp++; if (a_state !== 4'd0) begin n_bad++; $display("FAIL clear_mid_state got %0d want 0", a_state); end
    n_cmp++; if (a_count !== 16'd0) begin n_bad++; $display("FAIL clear_mid_count got %0d want 0", a_count); end
  endtask

  task automatic test_halt();
    push(S_IDLE, rb(), 1'b1, rb(), 4'hF);
    push(S_FETCH, 1'b1, rb(), rb(), 4'hF);
    push(S_DECODE, rb(), rb(), rb(), 4'hF);
    for (int unsigned i = 0; i < 20; i++) push(S_HALT, rb(), rb(), rb(), 4'hF);
    play();
    foreach (got[i]) begin
      n_cmp++; if (got[i] !== want[i]) begin n_bad++; $display("FAIL halt step %0d got %h want %h", i, got[i], want[i]); end
    end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; run = 1'b0;
    #1;
    n_cmp++; if (a_state !== 4'd0) begin n_bad++; $display("FAIL halt_clear_state got %0d want 0", a_state); end
    n_cmp++; if (a_count !== 16'd0) begin n_bad++; $display("FAIL halt_clear_count got %0d want 0", a_count); end
  endtask

  task automatic test_wrap();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; m_count = 0;
    push(S_IDLE, rb(), 1'b1, rb(), 4'hD);
    for (int unsigned i = 0; i < 5; i++) add_instr(4'hD, 0, 0, rb(), (i < 4) ? 1'b1 : 1'b0);
    play();
    foreach (got[i]) begin
      n_cmp++; if (got[i] !== want[i]) begin n_bad++; $display("FAIL wrap step %0d got %h want %h", i, got[i], want[i]); end
    end
    n_cmp++; if (a_count !== 16'd5) begin n_bad++; $display("FAIL wrap_count16 got %0d want 5", a_count); end
    n_cmp++; if (b_count !== 2'd1) begin n_bad++; $display("FAIL wrap_count2 got %0d want 1", b_count); end
    n_cmp++; if (b_state !== 4'd0) begin n_bad++; $display("FAIL wrap_idle2 got %0d want 0", b_state); end
  endtask

  task automatic test_no_timeout_no_trap();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; run = 1'b1; mem_ready = 1'b0; opcode = 4'h0;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if (b_state !== 4'd1) begin n_bad++; $display("FAIL notimeout cyc %0d got %0d want 1", i, b_state); end
      @(posedge clk); #1;
    end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; run = 1'b1; mem_ready = 1'b1; opcode = 4'hE;
    #1;
    n_cmp++; if (b_state !== 4'd0) begin n_bad++; $display("FAIL nop_idle got %0d want 0", b_state); end
    @(posedge clk); #1;
    n_cmp++; if (b_state !== 4'd1) begin n_bad++; $display("FAIL nop_fetch got %0d want 1", b_state); end
    @(posedge clk); #1;
    n_cmp++; if (b_state !== 4'd2) begin n_bad++; $display("FAIL nop_decode got %0d want 2", b_state); end
    n_cmp++; if (b_trp !== 1'b0) begin n_bad++; $display("FAIL nop_trap got %0d want 0", b_trp); end
    @(posedge clk); #1;
    n_cmp++; if (b_state !== 4'd1) begin n_bad++; $display("FAIL nop_refetch got %0d want 1", b_state); end
    n_cmp++; if (b_count !== 2'd1) begin n_bad++; $display("FAIL nop_count got %0d want 1", b_count); end
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_timeout();
    test_beq();
    test_random();
    test_clear_mid();
    test_halt();
    test_wrap();
    test_no_timeout_no_trap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Parametrised control sequencer for the multicycle machine. It replaces the fixed control unit, adds configurable opcode width, memory wait-state handshaking with timeout, conditional branch, jump, illegal-opcode trap to the exception vector, halt, run/stop gating, and a retired-instruction counter. It drives every datapath select and enable: PC, memory, IR, register file, ALU muxes and ALU-op.

## Interface
- OPCODE_W, 4, opcode width; opcodes with any bit above bit 3 set are illegal
- CNT_W, 16, retired-instruction counter width
- WAIT_W, 4, wait-counter width
- WAIT_LIMIT, 15, consecutive mem_ready-low cycles in one memory state before a trap; 0 disables the timeout
- TRAP_ENABLE, 1, when 0 an illegal opcode retires as a NOP
- clk  in  1  clock
- clear  in  1  synchronous active-high reset
- run  in  1  permits instruction start
- opcode  in  OPCODE_W  IR opcode field
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write, pc_write_cond, pc_or_data, mem_read, mem_write, ir_write, reg_write, alu_src_a  out  1 each  datapath enables/selects
- mem_to_reg, alu_src_b, alu_op, pc_source  out  2 each  mux selects (pc_source 3 = vector 'h400)
- halted  out  1  in HALT state
- trap  out  1  one-cycle pulse in TRAP
- state_out  out  4  current state code
- instr_count  out  CNT_W  retired instructions

## Operation
- State codes: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, EXEC_R 7, EXEC_I 8, WB_ALU 9, WB_IMM 10, BRANCH 11, JUMP 12, TRAP 13, HALT 14.
- Outputs are Moore decoded from state. Exception: in FETCH, ir_write and pc_write equal mem_ready. Every unlisted output is 0.
- IDLE: all outputs 0. If run=1, go to FETCH.
- FETCH: mem_read=1, pc_or_data=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. Stays in FETCH while mem_ready=0. Goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00, which precomputes the branch target. Next state by opcode:
  - 0x0–0x7: EXEC_R
  - 0x8 ADDI: EXEC_I
  - 0x9 LOAD and 0xA STORE: MEM_ADDR
  - 0xB LI: WB_IMM
  - 0xC BEQ: BRANCH
  - 0xD JUMP: JUMP
  - 0xF: HALT
  - anything else: TRAP, or retire if TRAP_ENABLE=0
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; then WB_ALU.
- EXEC_I and MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. EXEC_I then goes to WB_ALU. MEM_ADDR then goes to MEM_RD for LOAD or MEM_WR for STORE.
- MEM_RD: mem_read=1, pc_or_data=1; goes to MEM_WB when mem_ready=1.
- MEM_WR: mem_write=1, pc_or_data=1; retires when mem_ready=1.
- MEM_WB: reg_write=1, mem_to_reg=01.
- WB_ALU: reg_write=1, mem_to_reg=00.
- WB_IMM: reg_write=1, mem_to_reg=10.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. The PC updates only if zero=1.
- JUMP: pc_write=1, pc_source=10.
- TRAP: pc_write=1, pc_source=11, trap=1; then retires.
- HALT: halted=1. Stays in HALT until clear; run is ignored.
- Retire: the state MEM_WB, MEM_WR (on completion), WB_ALU, WB_IMM, BRANCH, JUMP or TRAP increments instr_count (mod 2^CNT_W). It then goes to FETCH if run=1, else IDLE. HALT does not retire.
- Wait counter:
  - Cleared on every state change.
  - Increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0.
  - When it equals WAIT_LIMIT (nonzero) with mem_ready still 0, next state is TRAP, regardless of TRAP_ENABLE.
  - mem_ready=1 in the same cycle wins over the timeout.
  - A FETCH timeout does not assert ir_write.

## Timing
- clear=1 at a clk edge sets: state IDLE, instr_count 0, wait counter 0. Outputs are then all 0, state_out=0. clear overrides run, mem_ready and any state, including mid-access.
- Cycles per instruction with mem_ready held 1 (FETCH through retire state inclusive):
  - R-type, ADDI, STORE: 4
  - LOAD: 5
  - LI, BEQ, JUMP, illegal: 3
- Each mem_ready=0 cycle in a memory state adds one cycle.
- Back-to-back: the cycle after a retire state is FETCH when run=1.
- trap and halted are never asserted together.

## Test plan
- Reset, then run=1, mem_ready=1, opcode 0x2 -> state sequence 1,2,7,9,1. reg_write=1 only in state 9, alu_op=10 in state 7. instr_count=1 after the retire.
- LOAD with mem_ready low for 3 cycles in MEM_RD -> MEM_RD lasts 4 cycles, then MEM_WB with mem_to_reg=01. Total 8 cycles.
- WAIT_LIMIT=15, mem_ready stuck 0 in FETCH -> TRAP entered after 15 stall cycles, pc_source=11, pc_write=1, ir_write never 1. Next state FETCH.
- BEQ with zero=0, then BEQ with zero=1 -> pc_write_cond=1 and pc_source=01 in both. The bench checks the PC updates only in the second.
- Opcode 0xF -> HALT, halted=1 held for 20 cycles with run toggling. clear -> IDLE, instr_count=0.
- Counter wrap with CNT_W=2: five retired JUMPs -> instr_count=1. run dropped during a retire -> next state IDLE.
